// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_prog
//  Purpose  : Serial pattern detector (Mealy, KMP-style) with a run-time
//             loadable N-bit pattern, optional overlapping detection, and a
//             saturating match counter. All outputs are registered.
//  Ports    : clk        rising-edge clock
//             rst        asynchronous active-low reset
//             en         qualifies `in`; the stream advances only when en=1
//             in         serial data bit
//             pat_load   load pat_in and restart detection (beats en/in)
//             pat_in     new pattern, bit N-1 is received first
//             cnt_clr    synchronous clear of match_cnt (beats an increment)
//             out        one-cycle match pulse
//             match_cnt  saturating match count
//             progress   number of pattern bits currently matched
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detect_prog #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1101,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in,
  input  logic                     pat_load,
  input  logic [N-1:0]             pat_in,
  input  logic                     cnt_clr,
  output logic                     out,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [$clog2(N+1)-1:0]   progress
);

  localparam int               c_state_w = $clog2(N+1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [N-1:0]     c_one     = {{(N-1){1'b0}}, 1'b1};

  logic [c_state_w-1:0] state_q, state_d;
  logic                 out_q,   out_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [N-1:0]         pat_q,   pat_d;
  logic [c_state_w-1:0] next_w;
  logic                 hit_w;

  // Bit `idx` of p; out-of-range indices read as 0.
  function automatic logic bit_at(input logic [N-1:0] p, input int idx);
    return |((p >> idx) & c_one);
  endfunction

  // KMP transition. The matched text is {pat[N-1 -: k], b}. Returns the
  // largest j (capped at N-1) whose length-j suffix of that text equals the
  // length-j pattern prefix. Writing prefix element i as pat[N-1-i], the
  // suffix element at position m is prefix element k-j+1+m. With k=N-1 and
  // b=pat[0] the cap makes this the longest proper prefix-suffix, so the
  // same function serves the overlapping post-match state.
  function automatic logic [c_state_w-1:0] kmp_next(
    input logic [N-1:0]         p,
    input logic [c_state_w-1:0] k,
    input logic                 b
  );
    logic [c_state_w-1:0] best;
    logic                 ok;
    best = '0;
    for (int j = 1; j < N; j++) begin
      if (j <= int'(k) + 1) begin
        ok = (b == bit_at(p, N - j));
        for (int m = 0; m < N - 2; m++) begin
          if (m < j - 1) begin
            ok = ok & (bit_at(p, N - 2 - int'(k) + j - m) == bit_at(p, N - 1 - m));
          end
        end
        if (ok) begin
          best = c_state_w'(j);
        end
      end
    end
    return best;
  endfunction

  assign next_w = kmp_next(pat_q, state_q, in);

  always_comb begin
    state_d = state_q;
    out_d   = 1'b0;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    hit_w   = 1'b0;
    if (pat_load) begin
      pat_d   = pat_in;
      state_d = '0;
    end else if (en) begin
      if ((state_q == c_state_w'(N - 1)) && (in == pat_q[0])) begin
        hit_w   = 1'b1;
        out_d   = 1'b1;
        state_d = OVERLAP ? next_w : '0;
      end else begin
        state_d = next_w;
      end
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit_w && (cnt_q != c_cnt_max)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
      pat_q   <= PATTERN;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign progress  = state_q;

endmodule
`default_nettype wire
